md5_mem_responder: RTL

Word-addressed memory responder on the target side of the md5 hasher's memory interface (mem_we / mem_addr / mem_write_data / mem_read_data). It serves message reads with one-cycle latency and accepts digest writes. It also captures the four digest words written into a configurable output window and flags completion. A secondary host port lets the testbench or system loader preload messages and read back memory, arbitrated against hasher writes.

---
 rtl/md5_mem_responder.sv | 107 ++++++++++
 1 files changed

// File: rtl/md5_mem_responder.sv
// Word-addressed memory target for the md5 hasher: 1-cycle read-first reads, digest writes,
// digest-window capture with completion flag, and an arbitrated host preload/readback port.
module md5_mem_responder #(
  parameter int ADDR_W       = 16,
  parameter int DEPTH        = 1024,
  parameter int DIGEST_WORDS = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mem_we,
  input  logic [ADDR_W-1:0]         mem_addr,
  input  logic [31:0]               mem_write_data,
  output logic [31:0]               mem_read_data,
  input  logic                      host_req,
  input  logic                      host_we,
  input  logic [ADDR_W-1:0]         host_addr,
  input  logic [31:0]               host_wdata,
  output logic                      host_gnt,
  output logic                      host_rvalid,
  output logic [31:0]               host_rdata,
  input  logic [ADDR_W-1:0]         digest_base,
  input  logic                      digest_clear,
  output logic [32*DIGEST_WORDS-1:0] digest,
  output logic                      digest_valid,
  output logic                      oob_err
);

  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SLOT_W = (DIGEST_WORDS > 1) ? $clog2(DIGEST_WORDS) : 1;
  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] DWORDS_L = ADDR_W'(DIGEST_WORDS);

  logic [31:0]             mem [DEPTH];
  logic [31:0]             slot_q [DIGEST_WORDS];
  logic [DIGEST_WORDS-1:0] mask_q;
  logic [DIGEST_WORDS-1:0] mask_base;
  logic [DIGEST_WORDS-1:0] mask_d;
  logic                    valid_base;
  logic                    valid_d;
  logic                    capture;
  logic [ADDR_W-1:0]       win_off;
  logic [SLOT_W-1:0]       slot;

  logic             mem_in;
  logic             host_in;
  logic [IDX_W-1:0] mem_idx;
  logic [IDX_W-1:0] host_idx;
  logic             hasher_wr;
  logic             host_wr;
  logic             host_rd;

  assign mem_in    = {1'b0, mem_addr} < DEPTH_L;
  assign host_in   = {1'b0, host_addr} < DEPTH_L;
  assign mem_idx   = mem_addr[IDX_W-1:0];
  assign host_idx  = host_addr[IDX_W-1:0];

  // Hasher wins write-write collisions; reads are never blocked.
  assign host_gnt  = host_req & ~(host_we & mem_we);
  assign hasher_wr = mem_we & mem_in;
  assign host_wr   = host_gnt & host_we & host_in;
  assign host_rd   = host_gnt & ~host_we;

  // Array has no reset so it maps onto block RAM; the two writers are mutually exclusive.
  always_ff @(posedge clk) begin
    if (hasher_wr) mem[mem_idx] <= mem_write_data;
    if (host_wr)   mem[host_idx] <= host_wdata;
  end

  // Clear acts first, so a same-cycle window write lands in an emptied mask.
  always_comb begin
    win_off    = mem_addr - digest_base;
    slot       = win_off[SLOT_W-1:0];
    mask_base  = digest_clear ? '0 : mask_q;
    valid_base = digest_clear ? 1'b0 : digest_valid;
    capture    = hasher_wr & (win_off < DWORDS_L) & ~valid_base;
    mask_d     = mask_base;
    if (capture) mask_d[slot] = 1'b1;
    valid_d    = valid_base | (&mask_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_read_data <= '0;
      host_rvalid   <= 1'b0;
      host_rdata    <= '0;
      oob_err       <= 1'b0;
      mask_q        <= '0;
      digest_valid  <= 1'b0;
      for (int unsigned i = 0; i < DIGEST_WORDS; i++) slot_q[i] <= '0;
    end else begin
      mem_read_data <= mem_in ? mem[mem_idx] : '0;
      host_rvalid   <= host_rd;
      if (host_rd) host_rdata <= host_in ? mem[host_idx] : '0;
      if (!mem_in || (host_gnt && !host_in)) oob_err <= 1'b1;
      mask_q        <= mask_d;
      digest_valid  <= valid_d;
      if (capture) slot_q[slot] <= mem_write_data;
    end
  end

  always_comb begin
    digest = '0;
    for (int unsigned i = 0; i < DIGEST_WORDS; i++)
      digest[(DIGEST_WORDS-1-i)*32 +: 32] = slot_q[i];
  end

endmodule
